// File: rtl/mw_seq_adder_pkg.sv
// Shared state encodings and sizing helpers for the multi-cycle wide adder.
package mw_seq_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int nchunk_f(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-slice build still needs a one-bit counter.
  function automatic int cnt_w_f(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/mw_seq_adder_cla.sv
// SIZE-bit carry-lookahead adder used for the per-cycle slice add.
module cla_adder
  import mw_seq_adder_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            ci,
  output logic [SIZE-1:0] s,
  output logic            co
);

  logic [SIZE-1:0] g;
  logic [SIZE-1:0] p;
  logic [SIZE:0]   c;
  logic            acc;
  logic            pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of generate terms gated by the propagate run below it.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = ci;
    for (int i = 0; i < SIZE; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & ci);
    end
  end

  assign s  = p ^ c[SIZE-1:0];
  assign co = c[SIZE];

endmodule

// File: rtl/mw_seq_adder.sv
// Multi-cycle wide adder: one CHUNK-bit slice per cycle, carry chained between cycles.
// Optional subtract mode enabled by defining MW_SEQ_ADDER_SUB_EN (adds the `sub` port).
module mw_seq_adder
  import mw_seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef MW_SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
  localparam int CNT_W  = cnt_w_f(NCHUNK);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_width
    $error("mw_seq_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [WIDTH-1:0]   b_acc;
  logic               cin_acc;
  logic [CHUNK-1:0]   slice_sum;
  logic               slice_co;
  logic [WIDTH-1:0]   sum_sh_nxt;
  logic               last_slice;

`ifdef MW_SEQ_ADDER_SUB_EN
  // a - b as a + ~b + 1; cout then reads as "no borrow".
  assign b_acc   = sub ? ~b : b;
  assign cin_acc = sub | cin;
`else
  assign b_acc   = b;
  assign cin_acc = cin;
`endif

  cla_adder #(
    .SIZE (CHUNK)
  ) u_cla (
    .a  (a_sh_q[CHUNK-1:0]),
    .b  (b_sh_q[CHUNK-1:0]),
    .ci (carry_q),
    .s  (slice_sum),
    .co (slice_co)
  );

  // New slice enters at the MSB end so the LSB slice lands at bit 0 after NCHUNK steps.
  assign sum_sh_nxt = (sum_sh_q >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
  assign last_slice = (cnt_q == CNT_W'(NCHUNK - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          a_sh_d  = a;
          b_sh_d  = b_acc;
          carry_d = cin_acc;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> CHUNK;
        b_sh_d   = b_sh_q >> CHUNK;
        sum_sh_d = sum_sh_nxt;
        carry_d  = slice_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_slice) begin
          state_d = S_DONE;
          sum_d   = sum_sh_nxt;
          cout_d  = slice_co;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Operand and partial-sum shifters are fully reloaded per operation and need no reset.
  always_ff @(posedge clk) begin
    a_sh_q   <= a_sh_d;
    b_sh_q   <= b_sh_d;
    sum_sh_q <= sum_sh_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_mw_seq_adder.sv
// Directed and randomized checks of mw_seq_adder at 16/4 and 4/4 configurations.
module tb_mw_seq_adder;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int NC = W / C;
  localparam int W1 = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;
`ifdef MW_SEQ_ADDER_SUB_EN
  logic         sub;
  logic         sub4;
`endif

  logic         in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
  logic [3:0]   a4, b4, sum4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs [8];

  mw_seq_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef MW_SEQ_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  mw_seq_adder #(.WIDTH(4), .CHUNK(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
`ifdef MW_SEQ_ADDER_SUB_EN
    .sub       (sub4),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4),
    .busy      (busy4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                       output logic [W-1:0] rs, output logic rc, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      step();
      guard++;
    end
    a        = oa;
    b        = ob;
    cin      = oc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    rs        = sum;
    rc        = cout;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    int           lat;
    int           cnt;
    logic [W:0]   q[$];
    logic [W:0]   e;
    logic [4:0]   q4[$];
    logic [4:0]   e4;
    int           cyc, last, acc, done;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[3] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef MW_SEQ_ADDER_SUB_EN
    sub = 1'b0; sub4 = 1'b0;
`endif
    step();
    step();
    chk("reset in_ready", 32'(in_ready), 32'(1));
    chk("reset out_valid", 32'(out_valid), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset sum", 32'(sum), 32'(0));
    chk("reset cout", 32'(cout), 32'(0));
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat);
      chk($sformatf("vec%0d sum", i), 32'(rs), 32'(vecs[i].s));
      chk($sformatf("vec%0d cout", i), 32'(rc), 32'(vecs[i].co));
      chk($sformatf("vec%0d latency", i), lat, NC);
    end

    // Back-pressure with ignored operand pulses during RUN and DONE
    a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
    step();
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      chk("bp in_ready run", 32'(in_ready), 32'(0));
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; in_valid = cnt[0];
      step();
      cnt++;
    end
    chk("bp latency", cnt, NC);
    for (int k = 0; k < 3; k++) begin
      chk("bp out_valid held", 32'(out_valid), 32'(1));
      chk("bp sum held", 32'(sum), 32'h5556);
      chk("bp cout held", 32'(cout), 32'(0));
      chk("bp in_ready done", 32'(in_ready), 32'(0));
      a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp out_valid after take", 32'(out_valid), 32'(0));
    chk("bp in_ready after take", 32'(in_ready), 32'(1));
    step();
    chk("bp not accepted", 32'(busy), 32'(0));
    chk("bp sum kept", 32'(sum), 32'h5556);

    // Reset during the second RUN cycle aborts the operation
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort out_valid", 32'(out_valid), 32'(0));
    chk("abort in_ready", 32'(in_ready), 32'(1));
    chk("abort sum", 32'(sum), 32'(0));
    chk("abort busy", 32'(busy), 32'(0));
    for (int k = 0; k < NC + 1; k++) begin
      step();
      chk("abort no result", 32'(out_valid), 32'(0));
    end
    do_op(16'h0001, 16'h0001, 1'b0, rs, rc, lat);
    chk("after abort sum", 32'(rs), 32'h0002);
    chk("after abort cout", 32'(rc), 32'(0));

`ifdef MW_SEQ_ADDER_SUB_EN
    sub = 1'b1;
    do_op(16'h0005, 16'h0007, 1'b0, rs, rc, lat);
    chk("sub 5-7 sum", 32'(rs), 32'hFFFE);
    chk("sub 5-7 cout", 32'(rc), 32'(0));
    do_op(16'h0007, 16'h0005, 1'b1, rs, rc, lat);
    chk("sub 7-5 sum", 32'(rs), 32'h0002);
    chk("sub 7-5 cout", 32'(rc), 32'(1));
    sub = 1'b0;
    do_op(16'h0005, 16'h0007, 1'b0, rs, rc, lat);
    chk("add mode sum", 32'(rs), 32'h000C);
    chk("add mode cout", 32'(rc), 32'(0));
`endif

    // Streaming: operands change every cycle, only the accepted ones count
    out_ready = 1'b1; in_valid = 1'b1;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    cyc = 0; last = 0; acc = 0; done = 0;
    while (done < 1000 && cyc < 1000 * (NC + 2) + 100) begin
      if (out_valid) begin
        e = (q.size() != 0) ? q.pop_front() : 'x;
        chk("rnd16 result", 32'({cout, sum}), 32'(e));
        done++;
      end
      if (in_ready) begin
        if (acc > 0) chk("rnd16 spacing", cyc - last, NC + 2);
        last = cyc;
        q.push_back(W1'(a) + W1'(b) + W1'(cin));
        acc++;
      end
      step();
      cyc++;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    in_valid = 1'b0;
    chk("rnd16 count", done, 1000);
    step();
    out_ready = 1'b0;

    out_ready4 = 1'b1; in_valid4 = 1'b1;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    cyc = 0; last = 0; acc = 0; done = 0;
    while (done < 200 && cyc < 200 * 3 + 50) begin
      if (out_valid4) begin
        e4 = (q4.size() != 0) ? q4.pop_front() : 'x;
        chk("rnd4 result", 32'({cout4, sum4}), 32'(e4));
        done++;
      end
      if (in_ready4) begin
        if (acc > 0) chk("rnd4 spacing", cyc - last, 3);
        last = cyc;
        q4.push_back(5'(a4) + 5'(b4) + 5'(cin4));
        acc++;
      end
      step();
      cyc++;
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    end
    in_valid4 = 1'b0;
    chk("rnd4 count", done, 200);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
